// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the dual-client external SRAM arbiter.
// Pure declarations: no latency, no flow control.
package sram_arb_pkg;

  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 8;

  localparam logic [SRAM_AW-1:0] DEF_BASE_A = 19'h00000;
  localparam logic [SRAM_AW-1:0] DEF_BASE_B = 19'h08000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Window translation; the carry out of bit 18 is dropped so windows wrap.
  function automatic logic [SRAM_AW-1:0] win_addr(input logic [SRAM_AW-1:0] base,
                                                  input logic [SRAM_AW-1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-input round-robin grant; combinational grant, last-served flag updates on advance.
// No backpressure of its own: the caller pulses advance only when it accepts the grant.
module sram_rr_arb (
  input  logic clock,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic advance,
  output logic grant_vld,
  output logic grant_b
);

  logic r_last_b;

  assign grant_vld = req_a | req_b;
  // On a tie, B wins only if A was the port served last.
  assign grant_b   = req_b & (~req_a | ~r_last_b);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_b <= 1'b1;
    end else if (advance && grant_vld) begin
      r_last_b <= grant_b;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two req/ack clients onto one async 8-bit SRAM; ack 2+STROBE_CYCLES clocks after grant.
// A waiting client simply holds req; no access is pre-empted once granted.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                 ADDR_WIDTH    = 15,
  parameter int                 DATA_WIDTH    = 8,
  parameter logic [SRAM_AW-1:0] BASE_A        = DEF_BASE_A,
  parameter logic [SRAM_AW-1:0] BASE_B        = DEF_BASE_B,
  parameter int                 STROBE_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  ack_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic [SRAM_AW-1:0]    sram_addr,
  inout  wire  [SRAM_DW-1:0]    sram_data,
  output logic                  sram_we_n,
  output logic                  sram_oe_n
);

  if (DATA_WIDTH != SRAM_DW || ADDR_WIDTH > SRAM_AW ||
      STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_param
    $error("sram_port_arbiter: illegal parameter combination");
  end

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_port_b;
  logic                  r_we;
  logic [SRAM_DW-1:0]    r_wdat;
  logic                  r_dq_oe;
  logic [SRAM_AW-1:0]    r_addr;
  logic                  r_we_n;
  logic                  r_oe_n;
  logic                  r_ack_a;
  logic                  r_ack_b;
  logic [SRAM_DW-1:0]    r_q_a;
  logic [SRAM_DW-1:0]    r_q_b;

  logic                  w_grant_vld;
  logic                  w_grant_b;
  logic                  w_advance;
  logic                  w_sel_we;
  logic [SRAM_DW-1:0]    w_sel_dat;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [SRAM_AW-1:0]    w_sel_base;
  logic [SRAM_AW-1:0]    w_off;

  assign w_advance = (r_state == IDLE);

  sram_rr_arb u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_a     (req_a),
    .req_b     (req_b),
    .advance   (w_advance),
    .grant_vld (w_grant_vld),
    .grant_b   (w_grant_b)
  );

  assign w_sel_we   = w_grant_b ? we_b      : we_a;
  assign w_sel_dat  = w_grant_b ? data_b    : data_a;
  assign w_sel_addr = w_grant_b ? address_b : address_a;
  assign w_sel_base = w_grant_b ? BASE_B    : BASE_A;
  assign w_off      = SRAM_AW'(w_sel_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_port_b <= 1'b0;
      r_we     <= 1'b0;
      r_wdat   <= '0;
      r_dq_oe  <= 1'b0;
      r_addr   <= '0;
      r_we_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_q_a    <= '0;
      r_q_b    <= '0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_port_b <= w_grant_b;
            r_we     <= w_sel_we;
            r_wdat   <= w_sel_dat;
            r_addr   <= win_addr(w_sel_base, w_off);
            // Data driver and output enable are mutually exclusive from SETUP on.
            r_dq_oe  <= w_sel_we;
            r_oe_n   <= w_sel_we;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_we_n  <= ~r_we;
          r_cnt   <= STROBE_LAST;
          r_state <= STROBE;
        end
        STROBE: begin
          if (r_cnt == 4'd0) begin
            r_we_n <= 1'b1;
            r_oe_n <= 1'b1;
            if (!r_we) begin
              if (r_port_b) r_q_b <= sram_data;
              else          r_q_a <= sram_data;
            end
            r_ack_a <= ~r_port_b;
            r_ack_b <= r_port_b;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        HOLD: begin
          r_dq_oe <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_data = r_dq_oe ? r_wdat : {SRAM_DW{1'bz}};
  assign sram_addr = r_addr;
  assign sram_we_n = r_we_n;
  assign sram_oe_n = r_oe_n;
  assign ack_a     = r_ack_a;
  assign ack_b     = r_ack_b;
  assign q_a       = r_q_a;
  assign q_b       = r_q_b;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (default timing; 3-cycle strobe with wrapping B window),
// each backed by a behavioural async SRAM; directed accesses with hand-computed results.
module tb_sram_port_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_a0 = 0, we_a0 = 0, req_b0 = 0, we_b0 = 0;
  logic [14:0] address_a0 = 0, address_b0 = 0;
  logic [7:0]  data_a0 = 0, data_b0 = 0;
  logic        ack_a0, ack_b0, sram_we_n0, sram_oe_n0;
  logic [7:0]  q_a0, q_b0;
  logic [18:0] sram_addr0;
  tri   [7:0]  sram_data0;

  logic        req_a1 = 0, we_a1 = 0, req_b1 = 0, we_b1 = 0;
  logic [14:0] address_a1 = 0, address_b1 = 0;
  logic [7:0]  data_a1 = 0, data_b1 = 0;
  logic        ack_a1, ack_b1, sram_we_n1, sram_oe_n1;
  logic [7:0]  q_a1, q_b1;
  logic [18:0] sram_addr1;
  tri   [7:0]  sram_data1;

  sram_port_arbiter u_dut0 (
    .clock(clock), .reset(reset),
    .req_a(req_a0), .we_a(we_a0), .address_a(address_a0), .data_a(data_a0), .ack_a(ack_a0), .q_a(q_a0),
    .req_b(req_b0), .we_b(we_b0), .address_b(address_b0), .data_b(data_b0), .ack_b(ack_b0), .q_b(q_b0),
    .sram_addr(sram_addr0), .sram_data(sram_data0), .sram_we_n(sram_we_n0), .sram_oe_n(sram_oe_n0)
  );

  sram_port_arbiter #(.BASE_B(19'h7FFF0), .STROBE_CYCLES(3)) u_dut1 (
    .clock(clock), .reset(reset),
    .req_a(req_a1), .we_a(we_a1), .address_a(address_a1), .data_a(data_a1), .ack_a(ack_a1), .q_a(q_a1),
    .req_b(req_b1), .we_b(we_b1), .address_b(address_b1), .data_b(data_b1), .ack_b(ack_b1), .q_b(q_b1),
    .sram_addr(sram_addr1), .sram_data(sram_data1), .sram_we_n(sram_we_n1), .sram_oe_n(sram_oe_n1)
  );

  // Behavioural async SRAMs; the pull-ups make an undriven bus read as 8'hFF.
  logic [7:0] mem0 [0:524287];
  logic [7:0] mem1 [0:524287];
  assign sram_data0 = (!sram_oe_n0 && sram_we_n0) ? mem0[sram_addr0] : 8'hzz;
  assign sram_data1 = (!sram_oe_n1 && sram_we_n1) ? mem1[sram_addr1] : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (sram_data0[g]);
    pullup (sram_data1[g]);
  end
  always @(negedge clock) begin
    if (!sram_we_n0) mem0[sram_addr0] <= sram_data0;
    if (!sram_we_n1) mem1[sram_addr1] <= sram_data1;
  end

  // Strobe low across an address change, or both enables low, is a protocol error.
  int          n_viol = 0;
  logic [18:0] prev_addr0 = '0;
  logic        prev_we0 = 1'b1;
  logic        prev_rst = 1'b1;
  always @(negedge clock) begin
    if (!reset && !prev_rst &&
        (((sram_addr0 !== prev_addr0) && (!sram_we_n0 || !prev_we0)) ||
         (!sram_we_n0 && !sram_oe_n0)))
      n_viol <= n_viol + 1;
    prev_addr0 <= sram_addr0;
    prev_we0   <= sram_we_n0;
    prev_rst   <= reset;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input bit pb, input bit rq, input bit we,
                       input logic [14:0] a, input logic [7:0] dt);
    if (d == 0 && !pb) begin req_a0 = rq; we_a0 = we; address_a0 = a; data_a0 = dt; end
    if (d == 0 &&  pb) begin req_b0 = rq; we_b0 = we; address_b0 = a; data_b0 = dt; end
    if (d == 1 && !pb) begin req_a1 = rq; we_a1 = we; address_a1 = a; data_a1 = dt; end
    if (d == 1 &&  pb) begin req_b1 = rq; we_b1 = we; address_b1 = a; data_b1 = dt; end
  endtask

  function automatic logic f_ack(input int d, input bit pb);
    if (d == 0) return pb ? ack_b0 : ack_a0;
    return pb ? ack_b1 : ack_a1;
  endfunction

  function automatic logic f_we_n(input int d);
    return (d == 0) ? sram_we_n0 : sram_we_n1;
  endfunction

  function automatic logic [18:0] f_addr(input int d);
    return (d == 0) ? sram_addr0 : sram_addr1;
  endfunction

  // One access: request on a falling edge, wait (bounded) for ack, check latency and address.
  task automatic access(input int d, input bit pb, input bit we, input logic [14:0] a,
                        input logic [7:0] dt, input int exp_lat, input logic [18:0] exp_addr,
                        input string tag, output int wecnt);
    int lat;
    lat   = 0;
    wecnt = 0;
    @(negedge clock);
    drive(d, pb, 1'b1, we, a, dt);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (!f_we_n(d)) wecnt++;
      if (f_ack(d, pb)) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_addr"}, f_addr(d), exp_addr);
    drive(d, pb, 1'b0, 1'b0, 15'h0, 8'h0);
  endtask

  initial begin
    int wc;
    int nack;
    int stray;
    int t_port [4];
    int t_lat  [4];
    logic [18:0] t_addr [4];

    repeat (3) @(negedge clock);
    chk("rst_ack_a", ack_a0, 0);
    chk("rst_ack_b", ack_b0, 0);
    chk("rst_q_a", q_a0, 0);
    chk("rst_q_b", q_b0, 0);
    chk("rst_we_n", sram_we_n0, 1);
    chk("rst_oe_n", sram_oe_n0, 1);
    chk("rst_addr", sram_addr0, 0);
    chk("rst_dz", sram_data0, 8'hFF);
    reset = 1'b0;

    // Simultaneous continuous requests: A wins the first tie, then strict alternation.
    for (int k = 0; k < 4; k++) begin t_port[k] = -1; t_lat[k] = -1; t_addr[k] = '1; end
    nack = 0;
    @(negedge clock);
    drive(0, 1'b0, 1'b1, 1'b1, 15'h0010, 8'h5A);
    drive(0, 1'b1, 1'b1, 1'b1, 15'h0010, 8'hC3);
    for (int i = 1; i <= 40 && nack < 4; i++) begin
      @(negedge clock);
      if (ack_a0 && nack < 4) begin t_port[nack] = 0; t_lat[nack] = i; t_addr[nack] = sram_addr0; nack++; end
      if (ack_b0 && nack < 4) begin t_port[nack] = 1; t_lat[nack] = i; t_addr[nack] = sram_addr0; nack++; end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 15'h0, 8'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 15'h0, 8'h0);
    chk("tie_acks", nack, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tie_port%0d", k), t_port[k], k % 2);
      chk($sformatf("tie_lat%0d", k), t_lat[k], 3 + 4 * k);
      chk($sformatf("tie_addr%0d", k), t_addr[k], (k % 2) ? 19'h08010 : 19'h00010);
    end
    chk("tie_mem_a", mem0[19'h00010], 8'h5A);
    chk("tie_mem_b", mem0[19'h08010], 8'hC3);

    // Reads back through both windows; a write must not disturb q.
    access(0, 1'b0, 1'b0, 15'h0010, 8'h00, 3, 19'h00010, "rdA", wc);
    chk("rdA_q", q_a0, 8'h5A);
    access(0, 1'b1, 1'b0, 15'h0010, 8'h00, 3, 19'h08010, "rdB", wc);
    chk("rdB_q", q_b0, 8'hC3);
    access(0, 1'b0, 1'b1, 15'h0040, 8'h96, 3, 19'h00040, "wrA40", wc);
    chk("wrA40_strobe", wc, 1);
    chk("wrA40_q_kept", q_a0, 8'h5A);
    chk("wrA40_mem", mem0[19'h00040], 8'h96);
    access(0, 1'b0, 1'b0, 15'h0040, 8'h00, 3, 19'h00040, "rdA40", wc);
    chk("rdA40_q", q_a0, 8'h96);

    // Reset during the write strobe abandons the access.
    @(negedge clock);
    drive(0, 1'b0, 1'b1, 1'b1, 15'h0020, 8'h77);
    @(negedge clock);
    @(negedge clock);
    chk("rstmid_in_strobe", sram_we_n0, 0);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 15'h0, 8'h0);
    @(negedge clock);
    chk("rstmid_we_n", sram_we_n0, 1);
    chk("rstmid_oe_n", sram_oe_n0, 1);
    chk("rstmid_dz", sram_data0, 8'hFF);
    chk("rstmid_ack", ack_a0, 0);
    chk("rstmid_q", q_a0, 0);
    reset = 1'b0;
    stray = 0;
    repeat (5) begin
      @(negedge clock);
      if (ack_a0 || ack_b0) stray++;
    end
    chk("rstmid_noack", stray, 0);
    access(0, 1'b0, 1'b1, 15'h0020, 8'h77, 3, 19'h00020, "rewrA", wc);
    access(0, 1'b0, 1'b0, 15'h0020, 8'h00, 3, 19'h00020, "rerdA", wc);
    chk("rerdA_q", q_a0, 8'h77);

    // Three-cycle strobe, and a B window that wraps past the top of SRAM.
    access(1, 1'b1, 1'b1, 15'h0020, 8'hE1, 5, 19'h00010, "s3wrB", wc);
    chk("s3wrB_strobe", wc, 3);
    chk("s3wrB_mem", mem1[19'h00010], 8'hE1);
    access(1, 1'b1, 1'b0, 15'h0020, 8'h00, 5, 19'h00010, "s3rdB", wc);
    chk("s3rdB_strobe", wc, 0);
    chk("s3rdB_q", q_b1, 8'hE1);

    chk("we_addr_overlap", n_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
